// File: rtl/mor1kx_pic_pkg.sv
// Shared constants, trigger-mode type and mode lookup for the vectored
// mor1kx programmable interrupt controller.
package mor1kx_pic_pkg;

    localparam logic [10:0] PIC_PICMR_OFS = 11'd0;
    localparam logic [10:0] PIC_PICSR_OFS = 11'd2;
    localparam int          PIC_ID_W      = 5;

    typedef enum logic [1:0] {
        PIC_LEVEL   = 2'd0,
        PIC_EDGE    = 2'd1,
        PIC_LATCHED = 2'd2
    } pic_mode_e;

    // Edge wins when a line is flagged in both masks.
    function automatic pic_mode_e pic_mode(input logic [4:0]  idx,
                                           input logic [31:0] edge_mask,
                                           input logic [31:0] latch_mask);
        if (edge_mask[idx]) return PIC_EDGE;
        if (latch_mask[idx]) return PIC_LATCHED;
        return PIC_LEVEL;
    endfunction

endpackage

// File: rtl/mor1kx_pic_prio_enc.sv
// Lowest-set-bit encoder: bit 0 is the highest priority interrupt.
module mor1kx_pic_prio_enc
    import mor1kx_pic_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]        req,
    output logic                any,
    output logic [PIC_ID_W-1:0] id
);

    always_comb begin
        id = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) id = PIC_ID_W'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/mor1kx_pic_vectored.sv
// SPR group 9 interrupt controller with per-line level/edge/latched
// triggering and a registered highest-priority vector for vectored dispatch.
module mor1kx_pic_vectored
    import mor1kx_pic_pkg::*;
#(
    parameter int          NUM_IRQS    = 32,
    parameter int          NMI_WIDTH   = 0,
    parameter logic [31:0] EDGE_MASK   = 32'h0,
    parameter logic [31:0] LATCH_MASK  = 32'h0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQS-1:0] irq_i,
    input  logic                spr_access_i,
    input  logic                spr_we_i,
    input  logic [15:0]         spr_addr_i,
    input  logic [31:0]         spr_dat_i,
    output logic                spr_bus_ack,
    output logic [31:0]         spr_dat_o,
    output logic [31:0]         spr_picmr_o,
    output logic [31:0]         spr_picsr_o,
    output logic                irq_o,
    output logic [4:0]          irq_id_o
);

    localparam logic [31:0] IMPL_MASK = (NUM_IRQS >= 32) ? 32'hFFFF_FFFF
                                      : ((32'h1 << NUM_IRQS) - 32'h1);
    localparam logic [31:0] NMI_ONES  = (NMI_WIDTH == 0) ? 32'h0
                                      : (32'hFFFF_FFFF >> (32 - NMI_WIDTH));

    logic [NUM_IRQS-1:0] irq_s;
    logic [NUM_IRQS-1:0] unmasked;
    logic [NUM_IRQS-1:0] picsr;
    logic [31:0]         picmr_q, picmr_d;
    logic [31:0]         dat_q, dat_d;
    logic [31:0]         picsr_ext, rd_data;
    logic                ack_q, ack_d;
    logic                irq_q, irq_d;
    logic [4:0]          irq_id_q, irq_id_d;
    logic                start, wr_en, wr_sr;
    logic [10:0]         ofs;
    logic                prio_any;
    logic [4:0]          prio_id;
    logic                unused_grp;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign irq_s = irq_i;
    end else begin : g_sync
        logic [NUM_IRQS-1:0] sync_q [SYNC_STAGES];
        logic [NUM_IRQS-1:0] sync_d [SYNC_STAGES];

        always_comb begin
            sync_d[0] = irq_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign irq_s = sync_q[SYNC_STAGES-1];
    end

    // Only the offset inside the group is decoded; the group bits are don't-care.
    assign ofs        = spr_addr_i[10:0];
    assign unused_grp = ^spr_addr_i[15:11];
    assign start      = spr_access_i & ~ack_q;
    assign wr_en      = start & spr_we_i;
    assign wr_sr      = wr_en & (ofs == PIC_PICSR_OFS);
    assign unmasked   = irq_s & picmr_q[NUM_IRQS-1:0];

    for (genvar g = 0; g < NUM_IRQS; g++) begin : g_line
        localparam pic_mode_e MODE = pic_mode(5'(g), EDGE_MASK, LATCH_MASK);

        if (MODE == PIC_LEVEL) begin : g_level
            assign picsr[g] = unmasked[g];
        end else begin : g_held
            logic pend_q, pend_d;
            logic set;

            if (MODE == PIC_EDGE) begin : g_edge
                logic unm_r_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) unm_r_q <= 1'b0;
                    else        unm_r_q <= unmasked[g];
                end
                assign set = unmasked[g] & ~unm_r_q;
            end else begin : g_latched
                assign set = unmasked[g];
            end

            // Set has priority over a same-cycle write-1 clear.
            assign pend_d = (pend_q & ~(wr_sr & spr_dat_i[g])) | set;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pend_q <= 1'b0;
                else        pend_q <= pend_d;
            end

            assign picsr[g] = pend_q;
        end
    end

    always_comb begin
        picsr_ext                 = '0;
        picsr_ext[NUM_IRQS-1:0]   = picsr;
    end

    always_comb begin
        picmr_d = picmr_q;
        if (wr_en && ofs == PIC_PICMR_OFS) picmr_d = (spr_dat_i | NMI_ONES) & IMPL_MASK;
    end

    always_comb begin
        case (ofs)
            PIC_PICMR_OFS: rd_data = picmr_q;
            PIC_PICSR_OFS: rd_data = picsr_ext;
            default:       rd_data = 32'h0;
        endcase
    end

    mor1kx_pic_prio_enc #(.W(NUM_IRQS)) u_prio (
        .req (picsr),
        .any (prio_any),
        .id  (prio_id)
    );

    always_comb begin
        ack_d    = start;
        dat_d    = start ? rd_data : dat_q;
        irq_d    = prio_any;
        irq_id_d = prio_any ? prio_id : irq_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            picmr_q  <= NMI_ONES & IMPL_MASK;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            picmr_q  <= picmr_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign spr_bus_ack = ack_q;
    assign spr_dat_o   = dat_q;
    assign spr_picmr_o = picmr_q;
    assign spr_picsr_o = picsr_ext;
    assign irq_o       = irq_q;
    assign irq_id_o    = irq_id_q;

endmodule

// File: doc/mor1kx_pic_vectored.md
# mor1kx_pic_vectored

Parametrised programmable interrupt controller for the mor1kx SPR group 9. It supports 1–32 lines, a per-line trigger mode (level, edge, or latched level) and an optional input synchroniser. It adds a registered highest-priority vector output (`irq_o`, `irq_id_o`) for vectored dispatch. It sits between the SoC interrupt sources and the CPU exception logic, on the SPR bus.

## Interface
Parameters:
- `NUM_IRQS`, 32: implemented lines, 1..32; unimplemented bits read 0.
- `NMI_WIDTH`, 0: lines [NMI_WIDTH-1:0] permanently unmasked; must be less than or equal to `NUM_IRQS`.
- `EDGE_MASK`, 32'h0: bit=1 makes that line rising-edge triggered.
- `LATCH_MASK`, 32'h0: bit=1 makes that line latched-level; `EDGE_MASK` wins if both bits are set. Lines with neither bit set are level.
- `SYNC_STAGES`, 2: flops on `irq_i` before detection, 0..3.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `irq_i`  in  NUM_IRQS  raw interrupt sources; may be asynchronous when `SYNC_STAGES` is 2 or more.
- `spr_access_i`  in  1  SPR request; held until `spr_bus_ack`.
- `spr_we_i`  in  1  write qualifier.
- `spr_addr_i`  in  16  SPR address; only the offset within group 9 is decoded.
- `spr_dat_i`  in  32  write data.
- `spr_bus_ack`  out  1  one-cycle acknowledge.
- `spr_dat_o`  out  32  read data, valid while `spr_bus_ack` is high.
- `spr_picmr_o`  out  32  mask register.
- `spr_picsr_o`  out  32  status register.
- `irq_o`  out  1  registered: some PICSR bit is set.
- `irq_id_o`  out  5  registered: index of the lowest set PICSR bit, which is the highest priority.

## Operation
- Synchroniser: `irq_s` is `irq_i` delayed `SYNC_STAGES` flops; with 0 stages, `irq_s` is `irq_i` directly.
- Unmasking: `unmasked = irq_s & picmr`.
- Level line:
  - PICSR bit equals `unmasked`, combinational.
  - Writes to the bit are ignored.
- Edge line:
  - Set on `unmasked & ~unmasked_r`, where `unmasked_r` is a per-line flop.
  - Writing 1 to the bit clears it.
  - If a set and a clear occur in the same cycle, set wins.
- Latched line:
  - Set while `unmasked` is high.
  - Writing 1 clears it; if `unmasked` is still high the bit re-sets, so it stays 1.
- PICMR:
  - Offset 0; read/write.
  - Bits [NMI_WIDTH-1:0] are forced to 1.
  - Bits at or above `NUM_IRQS` are forced to 0.
- PICSR: offset 2.
- Other offsets: reads return 0; writes are ignored; the access is still acked.
- SPR handshake:
  - When `spr_access_i` is high and `ack_r` is low, the next edge sets `ack_r` to 1, latches read data, and commits any write on that same edge.
  - `ack_r` then clears on the following edge.
  - A transaction takes at least 2 cycles.
  - If `spr_access_i` is still high on the cycle after the ack, a new transaction starts.
- Priority:
  - Each cycle, `irq_o` is registered from OR(PICSR).
  - `irq_id_o` is registered from the priority encode; it holds its previous value when PICSR is 0.
- Reset values:
  - PICMR = {(32-NMI_WIDTH) zeros, NMI_WIDTH ones}.
  - PICSR = 0; all sync flops and `unmasked_r` = 0.
  - `spr_bus_ack` = 0, `spr_dat_o` = 0, `irq_o` = 0, `irq_id_o` = 0.
- Reset mid-transaction: the transaction is dropped with no ack; the master reissues it.

## Timing
- Edge/latched path: `irq_i` rise → PICSR bit set after `SYNC_STAGES`+1 edges → `irq_o`/`irq_id_o` valid 1 edge later.
- Level path: PICSR follows after `SYNC_STAGES` edges → `irq_o` 1 edge later.
- Write commit: a PICMR write affects `unmasked` from the ack edge onward.
- Read-after-write: a read that follows a PICSR write returns post-write state.
- Ack latency: exactly 1 cycle after the request is sampled.

## Structure
- Shared package `mor1kx_pic_pkg`:
  - SPR offset constants `PIC_PICMR_OFS`=0 and `PIC_PICSR_OFS`=2.
  - `PIC_ID_W`=5.
  - Function `pic_mode(idx)` returning LEVEL/EDGE/LATCHED from the masks.
- Sub-module `mor1kx_pic_prio_enc`: parametrised-width lowest-set-bit encoder, combinational; outputs `any` and `id`.
- Per-line detection: a generate loop in the top module.

## Test plan
- Level line 3, `SYNC_STAGES`=2: write PICMR=0x8, raise `irq_i[3]`:
  - PICSR=0x8 after 2 edges.
  - `irq_o`=1 and `irq_id_o`=3 one edge later.
  - Dropping `irq_i` clears PICSR 2 edges later.
- Edge line 5 with a 1-cycle pulse: PICSR[5] stays set after the pulse ends. Write PICSR=0x20 on the same edge as a new rising edge; PICSR[5] remains 1.
- Latched line 7 held high: a write-1 clear leaves it at 1. Deassert the input, then clear again; it reads 0.
- Lines 2 and 9 pending simultaneously: `irq_id_o`=2. Clear line 2; `irq_id_o`=9 two edges later.
- `NMI_WIDTH`=2, `NUM_IRQS`=16: write PICMR=0xFFFFFFFC and read it back as 0x0000FFFF.
- Back-to-back accesses: ack on alternate cycles. Assert `rst_n`=0 during an access; there is no ack and all outputs take their reset values.
